exec_hazard_controller: RTL



---
 rtl/exec_hazard_controller.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/exec_hazard_controller.sv
// Execution-stage hazard and forwarding controller for the 7-stage pipeline
// (IF, ID, EX, DM1, DM2, DM3, WB).
//
// The controller tracks the destination register of each instruction in
// EX, DM1, DM2 and DM3. From that tracker it drives two groups of outputs:
// - the ALU operand mux selects, registered for the instruction entering EX;
// - stall and clear controls for the IF/ID, ID/EX and EX pipeline registers.
//
// Load data can only be forwarded from WB. A consumer therefore stalls while
// a matching load sits in EX, DM1 or DM2.
module exec_hazard_controller #(
    parameter logic HIGH = 1'b1,
    parameter logic LOW  = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_dec_valid,
    input  logic [4:0]  i_dec_rs1_address,
    input  logic [4:0]  i_dec_rs2_address,
    input  logic        i_dec_rs1_used,
    input  logic        i_dec_rs2_used,
    input  logic [4:0]  i_dec_rd_address,
    input  logic        i_dec_rd_write_enable,
    input  logic        i_dec_is_load,
    input  logic        i_branch_taken,
    input  logic        i_data_cache_ready,
    output logic [2:0]  o_alu_in1_mux_select,
    output logic [2:0]  o_alu_in2_mux_select,
    output logic        o_stall_fetch_stage,
    output logic        o_stall_decode_stage,
    output logic        o_stall_execution_stage,
    output logic        o_clear_fetch_stage,
    output logic        o_clear_decode_stage,
    output logic [31:0] o_stall_cycle_count
);

    // Operand mux encodings.
    localparam logic [2:0] SEL_RS  = 3'd0;
    localparam logic [2:0] SEL_IMM = 3'd1;
    localparam logic [2:0] SEL_DM1 = 3'd2;
    localparam logic [2:0] SEL_DM2 = 3'd3;
    localparam logic [2:0] SEL_DM3 = 3'd4;
    localparam logic [2:0] SEL_WB  = 3'd5;

    // Tracker slots. Index 0 = EX, 1 = DM1, 2 = DM2, 3 = DM3.
    // A slot in EX is forwarded from DM1 on the next cycle (code 2). Each
    // older slot shifts the forwarding source one stage further.
    logic [3:0] r_slot_valid;
    logic [3:0] r_slot_load;
    logic [4:0] r_slot_rd [0:3];

    logic [2:0]  r_sel1;
    logic [2:0]  r_sel2;
    logic [31:0] r_stall_cycle_count;

    logic [3:0] w_rs1_hit;
    logic [3:0] w_rs2_hit;
    logic [2:0] w_sel1;
    logic [2:0] w_sel2;
    logic       w_load_use;
    logic       w_freeze;
    logic       w_branch;
    logic       w_stall;
    logic       w_bubble;
    logic       w_ex_valid;

    // Per-slot source match: the slot is valid, its rd equals the source,
    // and the source is not x0.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hit
            assign w_rs1_hit[gi] = i_dec_rs1_used && r_slot_valid[gi] &&
                                   (i_dec_rs1_address != 5'd0) &&
                                   (r_slot_rd[gi] == i_dec_rs1_address);
            assign w_rs2_hit[gi] = i_dec_rs2_used && r_slot_valid[gi] &&
                                   (i_dec_rs2_address != 5'd0) &&
                                   (r_slot_rd[gi] == i_dec_rs2_address);
        end
    endgenerate

    // Youngest-first forwarding priority. An unused source takes PC/IMM.
    function automatic logic [2:0] f_select(input logic used, input logic [3:0] hit);
        logic [2:0] sel;
        sel = SEL_RS;
        if (!used)       sel = SEL_IMM;
        else if (hit[0]) sel = SEL_DM1;
        else if (hit[1]) sel = SEL_DM2;
        else if (hit[2]) sel = SEL_DM3;
        else if (hit[3]) sel = SEL_WB;
        return sel;
    endfunction

    assign w_sel1 = f_select(i_dec_rs1_used, w_rs1_hit);
    assign w_sel2 = f_select(i_dec_rs2_used, w_rs2_hit);

    // A load in DM3 reaches WB next cycle, so it forwards with no stall.
    // Only loads in EX, DM1 or DM2 block a real consumer.
    assign w_load_use = i_dec_valid &&
                        (|((w_rs1_hit[2:0] | w_rs2_hit[2:0]) & r_slot_load[2:0]));

    // Control priority: freeze > branch > load-use > advance.
    assign w_freeze = !i_data_cache_ready;
    assign w_branch = i_data_cache_ready && i_branch_taken;
    assign w_stall  = i_data_cache_ready && !i_branch_taken && w_load_use;
    assign w_bubble = w_branch || w_stall;

    assign w_ex_valid = i_dec_valid && i_dec_rd_write_enable &&
                        (i_dec_rd_address != 5'd0);

    assign o_stall_fetch_stage     = (w_freeze || w_stall) ? HIGH : LOW;
    assign o_stall_decode_stage    = (w_freeze || w_stall) ? HIGH : LOW;
    assign o_stall_execution_stage = w_freeze ? HIGH : LOW;
    assign o_clear_fetch_stage     = w_branch ? HIGH : LOW;
    assign o_clear_decode_stage    = w_bubble ? HIGH : LOW;

    assign o_alu_in1_mux_select = r_sel1;
    assign o_alu_in2_mux_select = r_sel2;
    assign o_stall_cycle_count  = r_stall_cycle_count;

    // EX slot: load the ID instruction, or a bubble on a branch or load-use.
    // Hold the slot during a freeze.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot_valid[0] <= 1'b0;
            r_slot_load[0]  <= 1'b0;
            r_slot_rd[0]    <= 5'd0;
        end else if (!w_freeze) begin
            if (w_bubble) begin
                r_slot_valid[0] <= 1'b0;
                r_slot_load[0]  <= 1'b0;
                r_slot_rd[0]    <= 5'd0;
            end else begin
                r_slot_valid[0] <= w_ex_valid;
                r_slot_load[0]  <= i_dec_is_load;
                r_slot_rd[0]    <= i_dec_rd_address;
            end
        end
    end

    generate
        for (gi = 1; gi < 4; gi++) begin : g_shift
            // Older slots shift one stage on every non-frozen edge.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_slot_valid[gi] <= 1'b0;
                    r_slot_load[gi]  <= 1'b0;
                    r_slot_rd[gi]    <= 5'd0;
                end else if (!w_freeze) begin
                    r_slot_valid[gi] <= r_slot_valid[gi-1];
                    r_slot_load[gi]  <= r_slot_load[gi-1];
                    r_slot_rd[gi]    <= r_slot_rd[gi-1];
                end
            end
        end
    endgenerate

    // Operand selects follow the instruction entering EX. A bubble gets
    // select 0. During a freeze the selects hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel1 <= SEL_RS;
            r_sel2 <= SEL_RS;
        end else if (!w_freeze) begin
            if (w_bubble) begin
                r_sel1 <= SEL_RS;
                r_sel2 <= SEL_RS;
            end else begin
                r_sel1 <= w_sel1;
                r_sel2 <= w_sel2;
            end
        end
    end

    // Count the cycles that lose an EX slot to a bubble. This never counts
    // during a freeze, because a bubble requires the cache to be ready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycle_count <= 32'd0;
        end else if (w_bubble) begin
            r_stall_cycle_count <= r_stall_cycle_count + 32'd1;
        end
    end

endmodule
